// File: rtl/root_disp_pkg.sv
// Shared types and constants for the square-root BCD display block.
package root_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned SHIFT_COUNT         = 11;
  localparam logic [6:0]  SEG_BLANK           = 7'h7F;
  localparam int unsigned REFRESH_DIV_DEFAULT = 50000;

  // One double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] r_adj;
    r_adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_adj[i*4 +: 4] >= 4'd5) r_adj[i*4 +: 4] = r_adj[i*4 +: 4] + 4'd3;
    end
    return r_adj;
  endfunction

endpackage

// File: rtl/root_bcd_display_seg7.sv
// BCD digit to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module seg7_decoder
  import root_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg = 7'h40;
      4'd1: o_seg = 7'h79;
      4'd2: o_seg = 7'h24;
      4'd3: o_seg = 7'h30;
      4'd4: o_seg = 7'h19;
      4'd5: o_seg = 7'h12;
      4'd6: o_seg = 7'h02;
      4'd7: o_seg = 7'h78;
      4'd8: o_seg = 7'h00;
      4'd9: o_seg = 7'h10;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/root_bcd_display.sv
// Converts an 8.8 fixed-point root to four BCD digits (TT.hh) and scans them
// onto a multiplexed four-digit active-low seven-segment display.
module root_bcd_display
  import root_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] root,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_root;
  logic [26:0]     r_shift;
  logic [3:0]      r_cnt;
  logic [15:0]     r_digits;
  logic [CW-1:0]   r_refresh;
  logic [1:0]      r_idx;

  logic [6:0]      w_frac;
  logic [10:0]     w_value;
  logic [15:0]     w_adj;
  logic [3:0]      w_digit;
  logic [6:0]      w_dec_seg;

  // Fraction to hundredths, truncated: floor(f * 100 / 256).
  assign w_frac  = 7'((16'(r_root[7:0]) * 16'd100) >> 8);
  assign w_value = 11'(r_root[15:8]) * 11'd100 + 11'(w_frac);
  assign w_adj   = dabble_adjust(r_shift[26:11]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = SCALE;
      SCALE: w_next = SHIFT;
      SHIFT: if (r_cnt == 4'(SHIFT_COUNT - 1)) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      IDLE:    busy = 1'b0;
      SCALE:   busy = 1'b1;
      SHIFT:   busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_root   <= '0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
    end else begin
      case (r_state)
        IDLE:  if (start) r_root <= root;
        SCALE: begin
          r_shift <= {16'h0000, w_value};
          r_cnt   <= '0;
        end
        SHIFT: begin
          r_shift <= 27'({w_adj, r_shift[10:0]} << 1);
          r_cnt   <= r_cnt + 4'd1;
        end
        DONE:  r_digits <= r_shift[26:11];
        default: ;
      endcase
    end
  end

  // Scan runs leftmost first: index 3 (tens) down to 0 (hundredths).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh <= '0;
      r_idx     <= 2'd3;
    end else if (r_refresh == CW'(REFRESH_DIV - 1)) begin
      r_refresh <= '0;
      r_idx     <= r_idx - 2'd1;
    end else begin
      r_refresh <= r_refresh + CW'(1);
    end
  end

  always_comb begin
    w_digit = r_digits[3:0];
    case (r_idx)
      2'd3: w_digit = r_digits[15:12];
      2'd2: w_digit = r_digits[11:8];
      2'd1: w_digit = r_digits[7:4];
      2'd0: w_digit = r_digits[3:0];
      default: w_digit = r_digits[3:0];
    endcase
  end

  seg7_decoder u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec_seg)
  );

  always_comb begin
    seg = w_dec_seg;
    if (r_idx == 2'd3 && w_digit == 4'd0) seg = SEG_BLANK;
    an = ~(4'b0001 << r_idx);
    dp = (r_idx == 2'd2) ? 1'b0 : 1'b1;
  end

endmodule
